// File: rtl/inst_fetch_bridge_if.sv
// inst_fetch_bridge_if: SRAM-like instruction bus between the fetch bridge (master) and memory (slave)
interface inst_fetch_bridge_if #(
    parameter int WIDTH = 32
);
    logic             bus_req;
    logic             bus_wr;
    logic [1:0]       bus_size;
    logic [WIDTH-1:0] bus_addr;
    logic             bus_addr_ok;
    logic             bus_data_ok;
    logic [WIDTH-1:0] bus_rdata;
    modport master (
        output bus_req, bus_wr, bus_size, bus_addr,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );
    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: fetch-stage responder with one-word buffer and single-outstanding instruction bus fetch
module inst_fetch_bridge #(
    parameter int WIDTH  = 32,
    parameter bit MAP_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_inst_ce,
    input  logic [WIDTH-1:0]    i_inst_addr,
    output logic [WIDTH-1:0]    o_inst_rdata,
    output logic                o_inst_stall,
    output logic                o_inst_adel,
    inst_fetch_bridge_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t           r_state;
    logic             r_buf_valid;
    logic             r_bus_req;
    logic [WIDTH-1:0] r_buf_pc;
    logic [WIDTH-1:0] r_buf_data;
    logic [WIDTH-1:0] r_req_pc;
    logic [WIDTH-1:0] r_bus_addr;
    logic             w_hit;
    logic             w_adel;
    logic             w_stall;
    logic             w_kseg;
    logic [WIDTH-1:0] w_map;
    assign w_hit   = r_buf_valid & (r_buf_pc == i_inst_addr);
    assign w_adel  = !rst & i_inst_ce & (i_inst_addr[1:0] != 2'b00);
    assign w_stall = !rst & i_inst_ce & !w_adel & !w_hit;
    // kseg0 and kseg1 both start with 2'b10; clearing the top three bits maps either
    assign w_kseg  = MAP_EN & (i_inst_addr[WIDTH-1 -: 2] == 2'b10);
    assign w_map   = w_kseg ? {3'b000, i_inst_addr[WIDTH-4:0]} : i_inst_addr;
    assign o_inst_rdata = w_hit ? r_buf_data : '0;
    assign o_inst_stall = w_stall;
    assign o_inst_adel  = w_adel;
    assign bus.bus_req  = r_bus_req;
    assign bus.bus_wr   = 1'b0;
    assign bus.bus_size = 2'b10;
    assign bus.bus_addr = r_bus_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_buf_valid <= 1'b0;
            r_buf_pc    <= '0;
            r_buf_data  <= '0;
            r_req_pc    <= '0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_stall) begin
                    r_req_pc   <= i_inst_addr;
                    r_bus_addr <= w_map;
                    r_bus_req  <= 1'b1;
                    r_state    <= ADDR;
                end
                ADDR: if (bus.bus_addr_ok) begin
                    r_bus_req <= 1'b0;
                    r_state   <= DATA;
                end
                DATA: if (bus.bus_data_ok) begin
                    r_buf_data  <= bus.bus_rdata;
                    r_buf_pc    <= r_req_pc;
                    r_buf_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: scoreboard bench driving the fetch bridge against a delay-configurable bus responder
module tb_inst_fetch_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_ce = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        inst_adel;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cnt = 0;
    int          addr_dly = 0;
    int          data_dly = 0;
    bit          late_mode = 1'b0;
    bit          late_go = 1'b0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_word_q[$];

    inst_fetch_bridge_if #(.WIDTH(32)) bif();

    inst_fetch_bridge #(.WIDTH(32), .MAP_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_inst_ce    (inst_ce),
        .i_inst_addr  (inst_addr),
        .o_inst_rdata (inst_rdata),
        .o_inst_stall (inst_stall),
        .o_inst_adel  (inst_adel),
        .bus          (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] pa);
        return {pa[15:0], ~pa[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory side: accepts a request after addr_dly cycles, returns data data_dly cycles later
    initial begin : responder
        logic [31:0] a;
        bif.bus_addr_ok = 1'b0;
        bif.bus_data_ok = 1'b0;
        bif.bus_rdata   = '0;
        @(negedge clk);
        forever begin
            if (bif.bus_req && !rst) begin
                a = bif.bus_addr;
                chk("bus_wr", {31'b0, bif.bus_wr}, 32'd0);
                chk("bus_size", {30'b0, bif.bus_size}, 32'd2);
                repeat (addr_dly) begin
                    @(negedge clk);
                    chk("req_hold", {31'b0, bif.bus_req}, 32'd1);
                    chk("addr_hold", bif.bus_addr, a);
                end
                bif.bus_addr_ok = 1'b1;
                chk("bus_addr", bif.bus_addr, exp_addr_q.size() > 0 ? exp_addr_q.pop_front() : 32'hFFFF_FFFF);
                req_cnt++;
                @(negedge clk);
                bif.bus_addr_ok = 1'b0;
                if (late_mode) begin
                    while (!late_go) @(negedge clk);
                    bif.bus_rdata = 32'hDEAD_BEEF;
                end else begin
                    repeat (data_dly) @(negedge clk);
                    bif.bus_rdata = mem_word(a);
                end
                bif.bus_data_ok = 1'b1;
                @(negedge clk);
                bif.bus_data_ok = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic wait_data(input string tag, input int exp_stall);
        int n = 0;
        #1;
        while (inst_stall && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_stall_end"}, {31'b0, inst_stall}, 32'd0);
        if (exp_stall >= 0) chk({tag, "_stall_cyc"}, n, exp_stall);
        chk({tag, "_rdata"}, inst_rdata, exp_word_q.size() > 0 ? exp_word_q.pop_front() : 32'hFFFF_FFFF);
    endtask

    task automatic fetch(input string tag, input logic [31:0] va, input logic [31:0] pa, input int exp_stall);
        inst_ce   = 1'b1;
        inst_addr = va;
        exp_addr_q.push_back(pa);
        exp_word_q.push_back(mem_word(pa));
        wait_data(tag, exp_stall);
    endtask

    initial begin
        int r0;
        inst_ce   = 1'b1;
        inst_addr = 32'hBFC0_0000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'b0, inst_stall}, 32'd0);
        chk("rst_adel", {31'b0, inst_adel}, 32'd0);
        chk("rst_rdata", inst_rdata, 32'd0);
        chk("rst_req", {31'b0, bif.bus_req}, 32'd0);
        chk("rst_addr", bif.bus_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fetch("t1", 32'hBFC0_0000, 32'h1FC0_0000, 3);

        @(negedge clk);
        addr_dly = 4;
        data_dly = 3;
        r0 = req_cnt;
        fetch("t2", 32'h8000_0010, 32'h0000_0010, 10);
        chk("t2_reqs", req_cnt - r0, 1);

        r0 = req_cnt;
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("t3_stall", {31'b0, inst_stall}, 32'd0);
            chk("t3_rdata", inst_rdata, mem_word(32'h0000_0010));
            chk("t3_req", {31'b0, bif.bus_req}, 32'd0);
        end
        chk("t3_reqs", req_cnt - r0, 0);

        @(negedge clk);
        addr_dly = 0;
        data_dly = 2;
        r0 = req_cnt;
        inst_addr = 32'hBFC0_0004;
        exp_addr_q.push_back(32'h1FC0_0004);
        exp_addr_q.push_back(32'h1FC0_0380);
        exp_word_q.push_back(mem_word(32'h1FC0_0380));
        #1;
        chk("t4_miss", {31'b0, inst_stall}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        inst_addr = 32'hBFC0_0380;
        wait_data("t4", 8);
        chk("t4_reqs", req_cnt - r0, 2);

        @(negedge clk);
        r0 = req_cnt;
        inst_addr = 32'hBFC0_0002;
        repeat (4) begin
            #1;
            chk("t5_adel", {31'b0, inst_adel}, 32'd1);
            chk("t5_stall", {31'b0, inst_stall}, 32'd0);
            chk("t5_rdata", inst_rdata, 32'd0);
            chk("t5_req", {31'b0, bif.bus_req}, 32'd0);
            @(negedge clk);
        end
        chk("t5_reqs", req_cnt - r0, 0);

        inst_ce   = 1'b0;
        inst_addr = 32'hBFC0_0802;
        data_dly  = 0;
        repeat (4) begin
            #1;
            chk("ce0_adel", {31'b0, inst_adel}, 32'd0);
            chk("ce0_stall", {31'b0, inst_stall}, 32'd0);
            chk("ce0_req", {31'b0, bif.bus_req}, 32'd0);
            @(negedge clk);
        end
        chk("ce0_reqs", req_cnt - r0, 0);

        fetch("useg", 32'h0040_0000, 32'h0040_0000, 3);
        @(negedge clk);
        fetch("kseg2", 32'hC000_0100, 32'hC000_0100, 3);

        @(negedge clk);
        late_mode = 1'b1;
        r0 = req_cnt;
        inst_addr = 32'hBFC0_0100;
        exp_addr_q.push_back(32'h1FC0_0100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_stall", {31'b0, inst_stall}, 32'd0);
        chk("t6_rst_rdata", inst_rdata, 32'd0);
        chk("t6_rst_req", {31'b0, bif.bus_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        inst_addr = 32'hC000_0100;
        exp_addr_q.push_back(32'hC000_0100);
        exp_word_q.push_back(mem_word(32'hC000_0100));
        #1;
        chk("t6_invalid", {31'b0, inst_stall}, 32'd1);
        @(negedge clk);
        #1;
        late_go   = 1'b1;
        late_mode = 1'b0;
        wait_data("t6", 4);
        chk("t6_reqs", req_cnt - r0, 2);

        @(negedge clk);
        chk("addr_q_left", exp_addr_q.size(), 0);
        chk("word_q_left", exp_word_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
